// File: rtl/debug_tx_framer_if.sv
// Bus bundle between the debug framer, the core's register file / data
// memory read ports and the UART transmitter. Clock and reset stay outside.
interface debug_tx_framer_if #(
   parameter int NB_DATA     = 32,
   parameter int N_BITS      = 8,
   parameter int NB_REG      = 5,
   parameter int NB_MEM_ADDR = 5
) ();

   logic                   start_i;
   logic [NB_DATA-1:0]     pc_i;
   logic [NB_DATA-1:0]     count_cycles_i;
   logic [NB_DATA-1:0]     data_reg_i;
   logic [NB_DATA-1:0]     data_mem_i;
   logic                   tx_done_i;
   logic                   tx_start_o;
   logic [N_BITS-1:0]      tx_data_o;
   logic [NB_REG-1:0]      addr_reg_o;
   logic                   read_reg_o;
   logic [NB_MEM_ADDR-1:0] addr_mem_o;
   logic                   read_mem_o;
   logic                   busy_o;
   logic                   end_send_data_o;

   // Framer side: consumes requests/read data, produces UART and read strobes
   modport master (
      input  start_i, pc_i, count_cycles_i, data_reg_i, data_mem_i, tx_done_i,
      output tx_start_o, tx_data_o, addr_reg_o, read_reg_o, addr_mem_o,
             read_mem_o, busy_o, end_send_data_o
   );

   // Environment side: core, memories and UART transmitter
   modport slave (
      output start_i, pc_i, count_cycles_i, data_reg_i, data_mem_i, tx_done_i,
      input  tx_start_o, tx_data_o, addr_reg_o, read_reg_o, addr_mem_o,
             read_mem_o, busy_o, end_send_data_o
   );

endinterface

// File: rtl/debug_tx_framer.sv
// Debug dump framer: streams PC, cycle count, the 32 registers and the data
// memory words to a byte-wide UART transmitter, LSB byte of each word first.
module debug_tx_framer #(
   parameter int NB_DATA     = 32,
   parameter int N_BITS      = 8,
   parameter int NB_REG      = 5,
   parameter int NB_MEM_ADDR = 5,
   parameter int N_MEM_WORDS = 32
) (
   input  logic              clock_i,
   input  logic              reset_i,
   debug_tx_framer_if.master bus
);

   localparam logic [3:0] IDLE      = 4'd0;
   localparam logic [3:0] SEND_BYTE = 4'd1;
   localparam logic [3:0] WAIT_DONE = 4'd2;
   localparam logic [3:0] REQ_CYC   = 4'd3;
   localparam logic [3:0] REQ_REG   = 4'd4;
   localparam logic [3:0] LOAD_REG  = 4'd5;
   localparam logic [3:0] REQ_MEM   = 4'd6;
   localparam logic [3:0] LOAD_MEM  = 4'd7;
   localparam logic [3:0] DONE      = 4'd8;

   // Which word of the dump is currently in the shift register
   localparam logic [1:0] SEC_PC  = 2'd0;
   localparam logic [1:0] SEC_CYC = 2'd1;
   localparam logic [1:0] SEC_REG = 2'd2;
   localparam logic [1:0] SEC_MEM = 2'd3;

   localparam int N_BYTES = NB_DATA / N_BITS;
   localparam int NB_BCNT = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

   localparam logic [NB_BCNT-1:0]     LAST_BYTE = NB_BCNT'(N_BYTES - 1);
   localparam logic [NB_REG-1:0]      LAST_REG  = NB_REG'(31);
   localparam logic [NB_MEM_ADDR-1:0] LAST_MEM  = NB_MEM_ADDR'(N_MEM_WORDS - 1);

   logic [3:0]             state_q,    state_d;
   logic [NB_DATA-1:0]     shift_q,    shift_d;
   logic [NB_DATA-1:0]     cyc_snap_q, cyc_snap_d;
   logic [NB_BCNT-1:0]     byte_cnt_q, byte_cnt_d;
   logic [NB_REG-1:0]      reg_idx_q,  reg_idx_d;
   logic [NB_MEM_ADDR-1:0] mem_idx_q,  mem_idx_d;
   logic [1:0]             sec_q,      sec_d;
   // Set when the word just loaded is the last of its section, so the
   // end-of-section decision never depends on an index wrapping to zero.
   logic                   last_q,     last_d;

   // Next-state and datapath decode for the dump sequencer
   always_comb begin
      // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latches).
      state_d    = state_q;
      shift_d    = shift_q;
      cyc_snap_d = cyc_snap_q;
      byte_cnt_d = byte_cnt_q;
      reg_idx_d  = reg_idx_q;
      mem_idx_d  = mem_idx_q;
      sec_d      = sec_q;
      last_d     = last_q;

      case (state_q)
         IDLE: begin
            if (bus.start_i) begin
               shift_d    = bus.pc_i;
               cyc_snap_d = bus.count_cycles_i;
               byte_cnt_d = '0;
               reg_idx_d  = '0;
               mem_idx_d  = '0;
               sec_d      = SEC_PC;
               last_d     = 1'b0;
               state_d    = SEND_BYTE;
            end
         end
         SEND_BYTE: state_d = WAIT_DONE;
         WAIT_DONE: begin
            if (bus.tx_done_i) begin
               shift_d = shift_q >> N_BITS;
               if (byte_cnt_q != LAST_BYTE) begin
                  byte_cnt_d = byte_cnt_q + 1'b1;
                  state_d    = SEND_BYTE;
               end else begin
                  byte_cnt_d = '0;
                  case (sec_q)
                     SEC_PC:  state_d = REQ_CYC;
                     SEC_CYC: state_d = REQ_REG;
                     SEC_REG: state_d = last_q ? REQ_MEM : REQ_REG;
                     default: state_d = last_q ? DONE : REQ_MEM;
                  endcase
               end
            end
         end
         REQ_CYC: begin
            shift_d = cyc_snap_q;
            sec_d   = SEC_CYC;
            last_d  = 1'b0;
            state_d = SEND_BYTE;
         end
         REQ_REG: state_d = LOAD_REG;
         LOAD_REG: begin
            shift_d   = bus.data_reg_i;
            last_d    = (reg_idx_q == LAST_REG);
            reg_idx_d = reg_idx_q + 1'b1;
            sec_d     = SEC_REG;
            state_d   = SEND_BYTE;
         end
         REQ_MEM: state_d = LOAD_MEM;
         LOAD_MEM: begin
            shift_d   = bus.data_mem_i;
            last_d    = (mem_idx_q == LAST_MEM);
            mem_idx_d = mem_idx_q + 1'b1;
            sec_d     = SEC_MEM;
            state_d   = SEND_BYTE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset abandons any dump in flight
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         cyc_snap_q <= '0;
         byte_cnt_q <= '0;
         reg_idx_q  <= '0;
         mem_idx_q  <= '0;
         sec_q      <= SEC_PC;
         last_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking updates so every register samples pre-edge values.
         state_q    <= state_d;
         shift_q    <= shift_d;
         cyc_snap_q <= cyc_snap_d;
         byte_cnt_q <= byte_cnt_d;
         reg_idx_q  <= reg_idx_d;
         mem_idx_q  <= mem_idx_d;
         sec_q      <= sec_d;
         last_q     <= last_d;
      end
   end

   // Moore outputs: strobes decoded from state, data/addresses straight from registers
   assign bus.tx_start_o      = (state_q == SEND_BYTE);
   assign bus.tx_data_o       = shift_q[N_BITS-1:0];
   assign bus.addr_reg_o      = reg_idx_q;
   assign bus.read_reg_o      = (state_q == REQ_REG) || (state_q == LOAD_REG);
   assign bus.addr_mem_o      = mem_idx_q;
   assign bus.read_mem_o      = (state_q == REQ_MEM) || (state_q == LOAD_MEM);
   assign bus.busy_o          = (state_q != IDLE);
   assign bus.end_send_data_o = (state_q == DONE);

endmodule

// File: tb/tb_debug_tx_framer.sv
// Self-checking bench for debug_tx_framer: a UART responder and register /
// memory read models surround the DUT, and a byte scoreboard holds the
// expected dump stream.
module tb_debug_tx_framer;

   localparam int NB_DATA     = 32;
   localparam int N_BITS      = 8;
   localparam int NB_REG      = 5;
   localparam int NB_MEM_ADDR = 5;
   localparam int N_MEM_WORDS = 32;
   localparam int DUMP_BYTES  = (2 + 32 + N_MEM_WORDS) * 4;
   localparam int TX_LATENCY  = 10;
   localparam int WAIT_BUDGET = 10000;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   debug_tx_framer_if #(
      .NB_DATA(NB_DATA), .N_BITS(N_BITS), .NB_REG(NB_REG), .NB_MEM_ADDR(NB_MEM_ADDR)
   ) bus ();

   debug_tx_framer #(
      .NB_DATA(NB_DATA), .N_BITS(N_BITS), .NB_REG(NB_REG),
      .NB_MEM_ADDR(NB_MEM_ADDR), .N_MEM_WORDS(N_MEM_WORDS)
   ) dut (
      .clock_i (clk),
      .reset_i (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [7:0] exp_q[$];

   int cyc_n      = 0;
   int n_starts   = 0;
   int n_end      = 0;
   int countdown  = 0;
   logic [7:0] held_byte = '0;
   logic reg_pend = 1'b0, mem_pend = 1'b0;
   logic [31:0] reg_val = '0, mem_val = '0;
   logic rd_prev    = 1'b0;
   int   rise_cyc   = 0;
   logic rise_armed = 1'b0;
   int   gap5       = -1;
   int   addr5_seen = 0;
   logic spur_en    = 1'b0;
   int   spur_hits  = 0;

   function automatic logic [31:0] reg_model(input int n);
      return 32'h1122_3300 + 32'(n);
   endfunction

   function automatic logic [31:0] mem_model(input int n);
      return 32'hC0DE_0000 | (32'(n) << 8) | 32'((~n) & 8'hFF);
   endfunction

   task automatic push_word(input logic [31:0] w);
      for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
   endtask

   task automatic push_dump(input logic [31:0] pc, input logic [31:0] cyc);
      push_word(pc);
      push_word(cyc);
      for (int r = 0; r < 32; r++) push_word(reg_model(r));
      for (int m = 0; m < N_MEM_WORDS; m++) push_word(mem_model(m));
   endtask

   // Environment model sampled 1 time unit after each rising edge
   always @(posedge clk) begin
      #1;
      cyc_n++;
      bus.tx_done_i  = 1'b0;
      // Read ports answer one cycle after the strobe; poison otherwise
      bus.data_reg_i = reg_pend ? reg_val : 32'hDEAD_BEEF;
      bus.data_mem_i = mem_pend ? mem_val : 32'hBAAD_F00D;
      reg_pend = bus.read_reg_o;
      reg_val  = reg_model(int'(bus.addr_reg_o));
      mem_pend = bus.read_mem_o;
      mem_val  = mem_model(int'(bus.addr_mem_o));
      if (!rst_n) begin
         countdown = 0;
         reg_pend  = 1'b0;
         mem_pend  = 1'b0;
         rd_prev   = 1'b0;
      end else begin
         if (countdown != 0) begin
            countdown--;
            if (countdown == 0) begin
               bus.tx_done_i = 1'b1;
               total++;
               if (bus.tx_data_o !== held_byte) begin
                  bad++;
                  $display("FAIL tx_data_hold: got %h expected %h", bus.tx_data_o, held_byte);
               end
            end
         end
         if (bus.read_reg_o && !rd_prev) begin
            rise_cyc = cyc_n;
            if (bus.addr_reg_o == 5'd5) begin
               rise_armed = 1'b1;
               addr5_seen++;
            end
            if (spur_en) begin
               bus.tx_done_i = 1'b1;
               spur_en = 1'b0;
               spur_hits++;
            end
         end
         rd_prev = bus.read_reg_o;
         if (bus.tx_start_o) begin
            n_starts++;
            if (rise_armed) begin
               gap5 = cyc_n - rise_cyc;
               rise_armed = 1'b0;
            end
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL tx_byte: got %h expected none (stream overrun)", bus.tx_data_o);
            end else begin
               logic [7:0] e;
               e = exp_q.pop_front();
               if (bus.tx_data_o !== e) begin
                  bad++;
                  $display("FAIL tx_byte #%0d: got %h expected %h", n_starts, bus.tx_data_o, e);
               end
            end
            held_byte = bus.tx_data_o;
            countdown = TX_LATENCY;
         end
         if (bus.end_send_data_o) n_end++;
      end
   end

   task automatic pulse_start();
      @(negedge clk);
      bus.start_i = 1'b1;
      @(negedge clk);
      bus.start_i = 1'b0;
   endtask

   // Runs one full dump; optional mid-dump disturbances
   task automatic run_dump(input logic [31:0] pc, input logic [31:0] cyc,
                           input bit disturb, input string tag);
      int base_starts, base_end, i;
      bit got_end;
      base_starts = n_starts;
      base_end    = n_end;
      bus.pc_i           = pc;
      bus.count_cycles_i = cyc;
      push_dump(pc, cyc);
      if (disturb) spur_en = 1'b1;
      pulse_start();
      total++;
      if (bus.busy_o !== 1'b1) begin
         bad++;
         $display("FAIL %s busy_after_start: got %b expected 1", tag, bus.busy_o);
      end
      got_end = 1'b0;
      i = 0;
      while (!got_end && i < WAIT_BUDGET) begin
         @(negedge clk);
         i++;
         if (i == 3) begin
            bus.count_cycles_i = 32'hFFFF_0BAD;
            bus.pc_i           = 32'hFFFF_1BAD;
         end
         bus.start_i = disturb && (i == 300 || i == 1500 || i == 2700);
         if (n_end != base_end) got_end = 1'b1;
      end
      bus.start_i = 1'b0;
      total++;
      if (!got_end) begin
         bad++;
         $display("FAIL %s end_timeout: got no end pulse expected one within %0d cycles", tag, WAIT_BUDGET);
      end else begin
         total++;
         if (bus.busy_o !== 1'b1 || bus.end_send_data_o !== 1'b1) begin
            bad++;
            $display("FAIL %s done_cycle: got busy=%b end=%b expected 1 1", tag, bus.busy_o, bus.end_send_data_o);
         end
         @(negedge clk);
         total++;
         if (bus.busy_o !== 1'b0 || bus.end_send_data_o !== 1'b0) begin
            bad++;
            $display("FAIL %s after_done: got busy=%b end=%b expected 0 0", tag, bus.busy_o, bus.end_send_data_o);
         end
      end
      repeat (20) @(negedge clk);
      total++;
      if (n_starts - base_starts !== DUMP_BYTES) begin
         bad++;
         $display("FAIL %s tx_start_count: got %0d expected %0d", tag, n_starts - base_starts, DUMP_BYTES);
      end
      total++;
      if (n_end - base_end !== 1) begin
         bad++;
         $display("FAIL %s end_pulse_count: got %0d expected 1", tag, n_end - base_end);
      end
      total++;
      if (exp_q.size() !== 0) begin
         bad++;
         $display("FAIL %s leftover_bytes: got %0d expected 0", tag, exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic check_outputs_zero(input string tag);
      total++;
      if (bus.tx_start_o !== 1'b0 || bus.tx_data_o !== 8'h00 || bus.busy_o !== 1'b0 ||
          bus.read_reg_o !== 1'b0 || bus.read_mem_o !== 1'b0 || bus.addr_reg_o !== 5'd0 ||
          bus.addr_mem_o !== 5'd0 || bus.end_send_data_o !== 1'b0) begin
         bad++;
         $display("FAIL %s outputs: got start=%b data=%h busy=%b rr=%b rm=%b ar=%h am=%h end=%b expected all 0",
                  tag, bus.tx_start_o, bus.tx_data_o, bus.busy_o, bus.read_reg_o,
                  bus.read_mem_o, bus.addr_reg_o, bus.addr_mem_o, bus.end_send_data_o);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_outputs_zero("idle_after_reset");
   endtask

   task automatic test_full_dump();
      gap5 = -1;
      addr5_seen = 0;
      run_dump(32'h0000_0010, 32'h0000_002A, 1'b0, "full_dump");
      total++;
      if (addr5_seen !== 1) begin
         bad++;
         $display("FAIL reg5_addr_strobe: got %0d occurrences expected 1", addr5_seen);
      end
      // Strobe seen in REQ_REG, capture in LOAD_REG, byte out in SEND_BYTE
      total++;
      if (gap5 !== 2) begin
         bad++;
         $display("FAIL reg5_read_to_send: got %0d cycles expected 2", gap5);
      end
   endtask

   task automatic test_disturbed_dump();
      spur_hits = 0;
      run_dump(32'hCAFE_0104, 32'h0001_2345, 1'b1, "disturbed");
      total++;
      if (spur_hits !== 1) begin
         bad++;
         $display("FAIL spurious_done_injected: got %0d expected 1", spur_hits);
      end
   endtask

   task automatic test_reset_mid_dump();
      int base_starts, base_end, i;
      base_starts = n_starts;
      base_end    = n_end;
      bus.pc_i           = 32'h0BAD_0000;
      bus.count_cycles_i = 32'h0000_0777;
      push_dump(32'h0BAD_0000, 32'h0000_0777);
      pulse_start();
      i = 0;
      while (n_starts - base_starts < 100 && i < WAIT_BUDGET) begin
         @(negedge clk);
         i++;
      end
      total++;
      if (n_starts - base_starts !== 100) begin
         bad++;
         $display("FAIL reset_mid reach_byte100: got %0d bytes expected 100", n_starts - base_starts);
      end
      @(negedge clk);
      total++;
      if (bus.busy_o !== 1'b1) begin
         bad++;
         $display("FAIL reset_mid busy_before: got %b expected 1", bus.busy_o);
      end
      #2 rst_n = 1'b0;
      #1 check_outputs_zero("reset_mid_immediate");
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      total++;
      if (n_end !== base_end || bus.busy_o !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid abandoned: got end_pulses=%0d busy=%b expected 0 0", n_end - base_end, bus.busy_o);
      end
      run_dump(32'h0000_0010, 32'h0000_002A, 1'b0, "after_reset");
   endtask

   initial begin
      bus.start_i        = 1'b0;
      bus.pc_i           = '0;
      bus.count_cycles_i = '0;
      bus.data_reg_i     = '0;
      bus.data_mem_i     = '0;
      bus.tx_done_i      = 1'b0;
      test_reset();
      test_full_dump();
      test_disturbed_dump();
      test_reset_mid_dump();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/debug_tx_framer.md
DEBUG_TX_FRAMER -- requirements
Module: debug_tx_framer

Interface
REQ-001 Parameters SHALL be:
  - NB_DATA, 32, word width
  - N_BITS, 8, UART byte width
  - NB_REG, 5, register address width
  - NB_MEM_ADDR, 5, data-memory word address width
  - N_MEM_WORDS, 32, data-memory words to dump
REQ-002 Ports SHALL be:
  - clock_i  in  1  single clock; sole clock of the block
  - reset_i  in  1  asynchronous, active-low reset
  - start_i  in  1  dump request, sampled only in IDLE
  - pc_i  in  NB_DATA  current PC
  - count_cycles_i  in  NB_DATA  executed-cycle counter
  - data_reg_i  in  NB_DATA  register-file read data
  - data_mem_i  in  NB_DATA  data-memory read data
  - tx_done_i  in  1  UART transmitter one-cycle byte-complete pulse
  - tx_start_o  out  1  one-cycle request to the UART transmitter
  - tx_data_o  out  N_BITS  byte to transmit
  - addr_reg_o  out  NB_REG  register read address
  - read_reg_o  out  1  register read strobe
  - addr_mem_o  out  NB_MEM_ADDR  data-memory read address
  - read_mem_o  out  1  data-memory read strobe
  - busy_o  out  1  dump in progress
  - end_send_data_o  out  1  one-cycle dump-complete pulse

Function
REQ-003 States SHALL be IDLE, SEND_BYTE, WAIT_DONE, REQ_CYC, REQ_REG, LOAD_REG, REQ_MEM, LOAD_MEM, DONE; all outputs SHALL be registered or decoded from the state only (Moore).
REQ-004 Dump order SHALL be: PC, cycle count, registers 0..31, memory words 0..N_MEM_WORDS-1, i.e. (2+32+N_MEM_WORDS) words = 264 bytes at the default parameters.
REQ-005 Each word SHALL be sent LSB byte first as 4 bytes; tx_data_o = word[7:0] of an internal shift register, which shifts right 8 on each accepted tx_done_i.
REQ-006 IDLE with start_i=1 at an edge: the block SHALL latch pc_i into the shift register, latch count_cycles_i into a snapshot register, clear the byte/index counters and enter SEND_BYTE.
REQ-007 start_i SHALL be ignored in every state other than IDLE.
REQ-008 SEND_BYTE SHALL assert tx_start_o for exactly one cycle, then enter WAIT_DONE; tx_data_o SHALL hold stable from SEND_BYTE until tx_done_i is accepted.
REQ-009 In WAIT_DONE with tx_done_i=1 and byte count < 3: increment byte count and return to SEND_BYTE.
REQ-010 In WAIT_DONE with tx_done_i=1 and byte count = 3, the next state SHALL be:
  - REQ_CYC after the PC word
  - REQ_REG after the cycle word or a register word with index < 31
  - REQ_MEM after register 31 or a memory word with index < N_MEM_WORDS-1
  - DONE after the last memory word
REQ-011 tx_done_i SHALL be ignored outside WAIT_DONE.
REQ-012 REQ_CYC SHALL load the snapshot cycle count into the shift register and enter SEND_BYTE (1 cycle).
REQ-013 REQ_REG SHALL drive read_reg_o=1 with addr_reg_o=index; LOAD_REG SHALL capture data_reg_i into the shift register (1-cycle read latency), increment the index and enter SEND_BYTE.
REQ-014 REQ_MEM/LOAD_MEM SHALL behave as REQ-013, using read_mem_o, addr_mem_o and data_mem_i.
REQ-015 Index counters SHALL be NB_REG and NB_MEM_ADDR bits wide; the end-of-section test SHALL compare against 31 and N_MEM_WORDS-1 and SHALL NOT rely on counter wrap.
REQ-016 DONE SHALL assert end_send_data_o for exactly one cycle and return to IDLE.
REQ-017 busy_o SHALL be 1 in every state except IDLE.
REQ-018 read_reg_o and read_mem_o SHALL be 0 outside REQ_REG/LOAD_REG and REQ_MEM/LOAD_MEM respectively.

Reset
REQ-019 reset_i=0 SHALL immediately force IDLE and clear all counters, the shift register and the snapshot register, with every output at 0, regardless of the current state.
REQ-020 A reset during a byte transfer SHALL abandon the dump; no end_send_data_o SHALL occur for it; the next dump SHALL restart at the PC word.

Verification
REQ-021 Start with pc_i=0x00000010, count_cycles_i=0x0000002A, tx_done_i returned 10 cycles after each tx_start_o -> bytes 10 00 00 00 2A 00 00 00, then the register and memory bytes.
REQ-022 Register model reg[n]=0x11223300+n -> register 5 transmitted as 05 33 22 11; addr_reg_o=5 with read_reg_o=1 one cycle before capture.
REQ-023 Full dump -> exactly 264 tx_start_o pulses, one end_send_data_o pulse after the last tx_done_i, busy_o low the following cycle.
REQ-024 start_i pulsed mid-dump, plus a spurious tx_done_i during REQ_REG -> byte stream and count unchanged.
REQ-025 count_cycles_i changes after start is accepted -> transmitted cycle word equals the value at start.
REQ-026 reset_i low during byte 100 -> all outputs 0 immediately; a new start_i re-sends from PC byte 0.
